pwm_compare_dt: RTL and testbench



---
 rtl/pwm_compare_dt_pkg.sv | 24 ++
 rtl/pwm_compare_dt_deadtime_gen.sv | 111 +++++++++++
 rtl/pwm_compare_dt.sv | 89 ++++++++
 tb/tb_pwm_compare_dt.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_compare_dt_pkg.sv
// Shared PWM types and constants: channel enable, dead-time FSM states and
// the default dead-time counter width.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package PKG_pwm;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } _pwm_onoff;

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        H_ON  = 3'd1,
        DT_HL = 3'd2,
        L_ON  = 3'd3,
        DT_LH = 3'd4
    } _dt_state;

    localparam int DT_WIDTH_DEF = 10;

endpackage

// File: rtl/pwm_compare_dt_deadtime_gen.sv
// Complementary gate driver with programmable dead time. Leaving a dead state
// early (abort) is allowed because the opposite switch was never enabled.
module deadtime_gen
    import PKG_pwm::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ref_q,
    input  logic [DT_WIDTH-1:0] deadtime,
    input  logic                on,
    output logic                pwm_h,
    output logic                pwm_l
);

    localparam logic [DT_WIDTH-1:0] CNT_ONE = DT_WIDTH'(1);

    _dt_state            state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                pwm_h_q, pwm_h_d;
    logic                pwm_l_q, pwm_l_d;
    logic                dt_zero_s;

    assign dt_zero_s = (deadtime == '0);

    // Next-state, counter and gate decode; gates come from the next state so
    // they are plain flops in step with the state register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!on) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF: begin
                    if (dt_zero_s) begin
                        state_d = ref_q ? H_ON : L_ON;
                    end else begin
                        state_d = ref_q ? DT_LH : DT_HL;
                        cnt_d   = deadtime;
                    end
                end
                H_ON: begin
                    if (ref_q) begin
                        state_d = H_ON;
                    end else if (dt_zero_s) begin
                        state_d = L_ON;
                    end else begin
                        state_d = DT_HL;
                        cnt_d   = deadtime;
                    end
                end
                L_ON: begin
                    if (!ref_q) begin
                        state_d = L_ON;
                    end else if (dt_zero_s) begin
                        state_d = H_ON;
                    end else begin
                        state_d = DT_LH;
                        cnt_d   = deadtime;
                    end
                end
                DT_HL: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (ref_q) begin
                        state_d = H_ON;
                    end else if (cnt_q <= CNT_ONE) begin
                        state_d = L_ON;
                    end else begin
                        state_d = DT_HL;
                    end
                end
                DT_LH: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (!ref_q) begin
                        state_d = L_ON;
                    end else if (cnt_q <= CNT_ONE) begin
                        state_d = H_ON;
                    end else begin
                        state_d = DT_LH;
                    end
                end
                default: begin
                    state_d = OFF;
                end
            endcase
        end
        pwm_h_d = (state_d == H_ON);
        pwm_l_d = (state_d == L_ON);
    end

    // State, counter and gate registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= OFF;
            cnt_q   <= '0;
            pwm_h_q <= 1'b0;
            pwm_l_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwm_h_q <= pwm_h_d;
            pwm_l_q <= pwm_l_d;
        end
    end

    assign pwm_h = pwm_h_q;
    assign pwm_l = pwm_l_q;

endmodule

// File: rtl/pwm_compare_dt.sv
// PWM compare stage: shadowed duty register, carrier comparator and gate
// drive. Dead-time insertion is built only when PWM_DEADTIME_EN is defined.
module pwm_compare_dt
    import PKG_pwm::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [`PWMCOUNT_WIDTH-1:0]   carrier,
    input  logic                         maskevent,
    input  logic [`PWMCOUNT_WIDTH-1:0]   compare,
    input  logic [DT_WIDTH-1:0]          deadtime,
    input  _pwm_onoff                    pwm_onoff,
    output logic [`PWMCOUNT_WIDTH-1:0]   compare_active,
    output logic                         pwm_h,
    output logic                         pwm_l
);

    logic [`PWMCOUNT_WIDTH-1:0] compare_active_q, compare_active_d;
    logic                       ref_q, ref_d;
    logic                       on_s;

    assign on_s = (pwm_onoff == PWM_ON);

    // Shadow load on maskevent only, so a mid-period write cannot tear a pulse.
    always_comb begin
        if (maskevent) begin
            compare_active_d = compare;
        end else begin
            compare_active_d = compare_active_q;
        end
        ref_d = (carrier < compare_active_q);
    end

    // Shadow and reference registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            compare_active_q <= '0;
            ref_q            <= 1'b0;
        end else begin
            compare_active_q <= compare_active_d;
            ref_q            <= ref_d;
        end
    end

    assign compare_active = compare_active_q;

`ifdef PWM_DEADTIME_EN
    deadtime_gen #(
        .DT_WIDTH (DT_WIDTH)
    ) u_deadtime_gen (
        .clk      (clk),
        .reset    (reset),
        .ref_q    (ref_q),
        .deadtime (deadtime),
        .on       (on_s),
        .pwm_h    (pwm_h),
        .pwm_l    (pwm_l)
    );
`else
    logic pwm_h_q, pwm_h_d;
    logic pwm_l_q, pwm_l_d;
    logic unused_dt_s;

    assign unused_dt_s = ^deadtime;

    // Plain complementary drive with no gap, one register after ref_q.
    always_comb begin
        pwm_h_d = ref_q && on_s;
        pwm_l_d = !ref_q && on_s;
    end

    // Gate registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_h_q <= 1'b0;
            pwm_l_q <= 1'b0;
        end else begin
            pwm_h_q <= pwm_h_d;
            pwm_l_q <= pwm_l_d;
        end
    end

    assign pwm_h = pwm_h_q;
    assign pwm_l = pwm_l_q;
`endif

endmodule

// File: tb/tb_pwm_compare_dt.sv
// Randomised bench for pwm_compare_dt against a run-length reference model;
// follows PWM_DEADTIME_EN the same way the design does.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module tb_pwm_compare_dt;
    import PKG_pwm::*;

    localparam int CW = `PWMCOUNT_WIDTH;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] carrier;
    logic          maskevent;
    logic [CW-1:0] compare;
    logic [DW-1:0] deadtime;
    _pwm_onoff     pwm_onoff;
    logic [CW-1:0] compare_active;
    logic          pwm_h;
    logic          pwm_l;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: shadow, reference, settled side and run length.
    int  m_ca;
    bit  m_r;
    bit  m_off;
    bit  m_s;
    int  m_k;
    int  m_d;
    bit  m_h;
    bit  m_l;
    int  car;

    pwm_compare_dt #(.DT_WIDTH(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .carrier        (carrier),
        .maskevent      (maskevent),
        .compare        (compare),
        .deadtime       (deadtime),
        .pwm_onoff      (pwm_onoff),
        .compare_active (compare_active),
        .pwm_h          (pwm_h),
        .pwm_l          (pwm_l)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ca = 0; m_r = 1'b0; m_off = 1'b1; m_s = 1'b0;
        m_k = 0; m_d = 0; m_h = 1'b0; m_l = 1'b0;
    endtask

    // One clock edge of the reference, from the inputs seen at that edge.
    task automatic model_edge();
        bit new_r;
        int new_ca;
        bit on;
        on     = (pwm_onoff == PWM_ON);
        new_r  = (int'(carrier) < m_ca);
        new_ca = maskevent ? int'(compare) : m_ca;
`ifdef PWM_DEADTIME_EN
        if (!on) begin
            m_off = 1'b1; m_h = 1'b0; m_l = 1'b0;
        end else begin
            if (m_off) begin
                m_off = 1'b0; m_s = !m_r; m_k = 0;
            end
            if (m_r == m_s) begin
                m_k = 0;
            end else begin
                m_k++;
                if (m_k == 1) m_d = int'(deadtime);
                if (m_k > m_d) begin
                    m_s = m_r; m_k = 0;
                end
            end
            m_h = (m_k == 0) &&  m_s;
            m_l = (m_k == 0) && !m_s;
        end
`else
        m_h = m_r && on;
        m_l = !m_r && on;
`endif
        m_r  = new_r;
        m_ca = new_ca;
    endtask

    task automatic check_all();
        check_eq("pwm_h", 32'(pwm_h), 32'(m_h));
        check_eq("pwm_l", 32'(pwm_l), 32'(m_l));
        check_eq("compare_active", 32'(compare_active), 32'(m_ca));
        check_eq("overlap", 32'(pwm_h & pwm_l), 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Up-counting carrier 0..period with maskevent on the wrap value.
    task automatic run_seg(input int period, input int cmp, input int dt, input int ncyc, input int on_pct);
        compare  = CW'(cmp);
        deadtime = DW'(dt);
        for (int i = 0; i < ncyc; i++) begin
            if (car > period) car = 0;
            carrier   = CW'(car);
            maskevent = (car == period);
            pwm_onoff = ($urandom_range(0, 99) < on_pct) ? PWM_ON : PWM_OFF;
            car       = (car == period) ? 0 : car + 1;
            cycle();
        end
        pwm_onoff = PWM_ON;
    endtask

    // Reset pulled mid-cycle must clear the gates before the next edge.
    task automatic mid_reset();
        @(posedge clk);
        model_edge();
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_h", 32'(pwm_h), 32'd0);
        check_eq("async_rst_l", 32'(pwm_l), 32'd0);
        check_eq("async_rst_ca", 32'(compare_active), 32'd0);
        model_reset();
        @(negedge clk);
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; carrier = '0; maskevent = 1'b0; compare = '0;
        deadtime = '0; pwm_onoff = PWM_OFF; car = 0;
        model_reset();
        #1;
        check_eq("reset_h", 32'(pwm_h), 32'd0);
        check_eq("reset_l", 32'(pwm_l), 32'd0);
        check_eq("reset_ca", 32'(compare_active), 32'd0);
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;
        pwm_onoff = PWM_ON;

        run_seg(40, 16'h0100, 0, 60, 100);
        run_seg(9, 4, 0, 60, 100);
        run_seg(9, 4, 3, 60, 100);
        run_seg(9, 1, 3, 60, 100);
        run_seg(9, 4, 3, 60, 92);
        run_seg(9, 6, 2, 7, 100);
        mid_reset();
        run_seg(9, 4, 3, 40, 100);
        run_seg(9, 0, 3, 30, 100);
        run_seg(9, 12, 3, 30, 100);

        for (int s = 0; s < 24; s++) begin
            int p;
            p = $urandom_range(3, 30);
            run_seg(p, $urandom_range(0, p + 2), $urandom_range(0, 6), 80, 96);
            if (s % 6 == 5) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
